// File: rtl/hilo_muldiv_unit.sv
// HI/LO multiply-divide unit: multi-cycle MULT/DIV/MADD/MSUB with MTHI/MTLO writes.
// Results are computed from the latched operands and committed when the busy counter expires.
module hilo_muldiv_unit #(
  parameter int W           = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   op,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         flush,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic         busy,
  output logic         done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  localparam logic [3:0] MULT_LOAD = MULT_CYCLES[3:0];
  localparam logic [3:0] DIV_LOAD  = DIV_CYCLES[3:0];
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  state_t       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [3:0]   op_q, op_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [W-1:0] hi_q, hi_d;
  logic [W-1:0] lo_q, lo_d;
  logic         done_q, done_d;

  logic               signedOp;
  logic [2*W-1:0]     prodSigned, prodUnsigned, mulTerm, hiloNow;
  logic               divOverflow, divByZero;
  logic [W-1:0]       safeDivisor;
  logic signed [W-1:0] quotS, remS;
  logic [W-1:0]       quotU, remU;

  // Divisor is forced to 1 for the zero and overflow cases so the dividers never see them.
  always_comb begin
    signedOp     = (op_q == OP_MULT) || (op_q == OP_DIV) ||
                   (op_q == OP_MADD) || (op_q == OP_MSUB);
    prodSigned   = {{W{a_q[W-1]}}, a_q} * {{W{b_q[W-1]}}, b_q};
    prodUnsigned = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};
    mulTerm      = signedOp ? prodSigned : prodUnsigned;
    hiloNow      = {hi_q, lo_q};
    divByZero    = (b_q == '0);
    divOverflow  = (a_q == MIN_NEG) && (b_q == '1);
    safeDivisor  = (divByZero || divOverflow) ? {{(W-1){1'b0}}, 1'b1} : b_q;
    quotS        = $signed(a_q) / $signed(safeDivisor);
    remS         = $signed(a_q) % $signed(safeDivisor);
    quotU        = a_q / safeDivisor;
    remU         = a_q % safeDivisor;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          case (op)
            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
              state_d = RUN;
              cnt_d   = MULT_LOAD;
              op_d    = op;
              a_d     = a;
              b_d     = b;
            end
            OP_DIV, OP_DIVU: begin
              state_d = RUN;
              cnt_d   = DIV_LOAD;
              op_d    = op;
              a_d     = a;
              b_d     = b;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q <= 4'd1) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
          done_d  = 1'b1;
          case (op_q)
            OP_MULT, OP_MULTU:  {hi_d, lo_d} = mulTerm;
            OP_MADD, OP_MADDU:  {hi_d, lo_d} = hiloNow + mulTerm;
            OP_MSUB, OP_MSUBU:  {hi_d, lo_d} = hiloNow - mulTerm;
            OP_DIV: begin
              if (divOverflow) begin
                lo_d = MIN_NEG;
                hi_d = '0;
              end else if (!divByZero) begin
                lo_d = quotS;
                hi_d = remS;
              end
            end
            OP_DIVU: begin
              if (!divByZero) begin
                lo_d = quotU;
                hi_d = remU;
              end
            end
            default: ;
          endcase
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 4'd0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q == RUN);
  assign done = done_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit (W=32, MULT_CYCLES=5, DIV_CYCLES=10).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_hilo_muldiv_unit;

  logic        clk;
  logic        reset;
  logic [3:0]  op;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int vectors;
  int miscompares;

  hilo_muldiv_unit #(.W(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .op(op), .start(start), .a(a), .b(b),
    .flush(flush), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive one start cycle, returning at the falling edge of the first cycle after it.
  task automatic applyStimulus(input logic [3:0] opIn, input logic [31:0] aIn, input logic [31:0] bIn);
    @(negedge clk);
    op = opIn; a = aIn; b = bIn; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
  endtask

  // Called in busy cycle startCycle; expects done exactly after n busy cycles.
  task automatic waitCommit(input int n, input int startCycle);
    int cycles;
    checkOutput("busy_running", {31'd0, busy}, 32'd1);
    cycles = startCycle;
    while (done !== 1'b1 && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("latency", cycles, n + 1);
    checkOutput("done_pulse", {31'd0, done}, 32'd1);
    checkOutput("busy_cleared", {31'd0, busy}, 32'd0);
    @(negedge clk);
    checkOutput("done_single", {31'd0, done}, 32'd0);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b0; op = 4'd0; start = 1'b0; a = '0; b = '0; flush = 1'b0;
    #1;
    checkOutput("reset_hi", hi, 32'h0);
    checkOutput("reset_lo", lo, 32'h0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    applyStimulus(4'd1, 32'hFFFFFFFF, 32'd2);
    waitCommit(5, 1);
    checkOutput("mult_hi", hi, 32'hFFFFFFFF);
    checkOutput("mult_lo", lo, 32'hFFFFFFFE);

    applyStimulus(4'd2, 32'hFFFFFFFF, 32'd2);
    waitCommit(5, 1);
    checkOutput("multu_hi", hi, 32'h00000001);
    checkOutput("multu_lo", lo, 32'hFFFFFFFE);

    applyStimulus(4'd3, 32'hFFFFFFF9, 32'd2);
    waitCommit(10, 1);
    checkOutput("div_lo", lo, 32'hFFFFFFFD);
    checkOutput("div_hi", hi, 32'hFFFFFFFF);

    applyStimulus(4'd3, 32'h80000000, 32'hFFFFFFFF);
    waitCommit(10, 1);
    checkOutput("divovf_lo", lo, 32'h80000000);
    checkOutput("divovf_hi", hi, 32'h0);

    applyStimulus(4'd4, 32'd100, 32'd7);
    waitCommit(10, 1);
    checkOutput("divu_lo", lo, 32'd14);
    checkOutput("divu_hi", hi, 32'd2);

    applyStimulus(4'd5, 32'd0, 32'd0);
    checkOutput("mthi_hi", hi, 32'd0);
    applyStimulus(4'd6, 32'd5, 32'd0);
    checkOutput("mtlo_lo", lo, 32'd5);
    checkOutput("mtlo_busy", {31'd0, busy}, 32'd0);
    checkOutput("mtlo_done", {31'd0, done}, 32'd0);

    applyStimulus(4'd7, 32'd3, 32'd4);
    waitCommit(5, 1);
    checkOutput("madd_lo", lo, 32'h11);
    checkOutput("madd_hi", hi, 32'h0);

    applyStimulus(4'd10, 32'd1, 32'h12);
    waitCommit(5, 1);
    checkOutput("msubu_hi", hi, 32'hFFFFFFFF);
    checkOutput("msubu_lo", lo, 32'hFFFFFFFF);

    applyStimulus(4'd15, 32'h1234, 32'h1);
    checkOutput("illegal_busy", {31'd0, busy}, 32'd0);
    checkOutput("illegal_lo", lo, 32'hFFFFFFFF);
    applyStimulus(4'd0, 32'h1234, 32'h1);
    checkOutput("nop_hi", hi, 32'hFFFFFFFF);

    applyStimulus(4'd5, 32'hA, 32'd0);
    applyStimulus(4'd6, 32'hB, 32'd0);
    applyStimulus(4'd4, 32'd7, 32'd0);
    waitCommit(10, 1);
    checkOutput("divz_hi", hi, 32'hA);
    checkOutput("divz_lo", lo, 32'hB);

    applyStimulus(4'd1, 32'd2, 32'd3);
    repeat (2) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_busy", {31'd0, busy}, 32'd0);
    checkOutput("flush_done", {31'd0, done}, 32'd0);
    checkOutput("flush_hi", hi, 32'hA);
    checkOutput("flush_lo", lo, 32'hB);
    @(negedge clk);
    checkOutput("flush_nodone", {31'd0, done}, 32'd0);

    applyStimulus(4'd1, 32'd2, 32'd3);
    op = 4'd5; a = 32'h55; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    checkOutput("mthi_in_run", hi, 32'hA);
    waitCommit(5, 2);
    checkOutput("mult2_hi", hi, 32'h0);
    checkOutput("mult2_lo", lo, 32'd6);

    applyStimulus(4'd2, 32'd3, 32'd3);
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flushexp_busy", {31'd0, busy}, 32'd0);
    checkOutput("flushexp_done", {31'd0, done}, 32'd0);
    checkOutput("flushexp_lo", lo, 32'd6);

    @(negedge clk);
    op = 4'd1; a = 32'd9; b = 32'd9; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0; op = 4'd0;
    checkOutput("flushstart_busy", {31'd0, busy}, 32'd0);

    applyStimulus(4'd5, 32'h77, 32'd0);
    applyStimulus(4'd3, 32'd100, 32'd3);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("midreset_hi", hi, 32'h0);
    checkOutput("midreset_lo", lo, 32'h0);
    checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
    op = 4'd1; a = 32'd5; b = 32'd7; start = 1'b1;
    #1 reset = 1'b1;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    waitCommit(5, 1);
    checkOutput("postreset_hi", hi, 32'h0);
    checkOutput("postreset_lo", lo, 32'd35);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
